// File: rtl/bus_decoder.sv
// One-client, two-server bus decoder: a captured request is routed to server 0 or 1
// by address, with a REQ-cycle timeout that aborts with an all-ones read and an err pulse.
module bus_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int SPLIT_ADDR = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [ADDR_WIDTH-1:0] client_address,
  input  logic                  client_rq,
  input  logic                  client_wr_ni,
  input  logic [DATA_WIDTH-1:0] client_dataW,
  output logic                  client_ack,
  output logic [DATA_WIDTH-1:0] client_dataR,

  output logic [ADDR_WIDTH-1:0] srv0_address,
  output logic                  srv0_rq,
  output logic                  srv0_wr_ni,
  output logic [DATA_WIDTH-1:0] srv0_dataW,
  input  logic                  srv0_ack,
  input  logic [DATA_WIDTH-1:0] srv0_dataR,

  output logic [ADDR_WIDTH-1:0] srv1_address,
  output logic                  srv1_rq,
  output logic                  srv1_wr_ni,
  output logic [DATA_WIDTH-1:0] srv1_dataW,
  input  logic                  srv1_ack,
  input  logic [DATA_WIDTH-1:0] srv1_dataR,

  output logic                  err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH:0] SPLIT_CMP = (ADDR_WIDTH + 1)'(SPLIT_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DROP = 2'd3
  } state_e;

  state_e                state_q,        state_d;
  logic                  sel_q,          sel_d;
  logic [CNT_W-1:0]      cnt_q,          cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q,         addr_d;
  logic                  wr_ni_q,        wr_ni_d;
  logic [DATA_WIDTH-1:0] dataw_q,        dataw_d;
  logic [DATA_WIDTH-1:0] rdata_q,        rdata_d;
  logic                  timeout_q,      timeout_d;
  logic                  srv0_rq_q,      srv0_rq_d;
  logic                  srv1_rq_q,      srv1_rq_d;
  logic                  client_ack_q,   client_ack_d;
  logic [DATA_WIDTH-1:0] client_datar_q, client_datar_d;
  logic                  err_q,          err_d;

  // Only the selected server's ack and read data are ever looked at.
  logic                  sel_ack;
  logic [DATA_WIDTH-1:0] sel_datar;

  assign sel_ack   = sel_q ? srv1_ack   : srv0_ack;
  assign sel_datar = sel_q ? srv1_dataR : srv0_dataR;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned (which would infer a latch); always_comb uses blocking '='.
    state_d        = state_q;
    sel_d          = sel_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wr_ni_d        = wr_ni_q;
    dataw_d        = dataw_q;
    rdata_d        = rdata_q;
    timeout_d      = timeout_q;
    srv0_rq_d      = srv0_rq_q;
    srv1_rq_d      = srv1_rq_q;
    client_ack_d   = 1'b0;
    client_datar_d = client_datar_q;
    err_d          = 1'b0;

    case (state_q)
      IDLE: begin
        if (client_rq) begin
          addr_d    = client_address;
          wr_ni_d   = client_wr_ni;
          dataw_d   = client_dataW;
          sel_d     = ({1'b0, client_address} >= SPLIT_CMP);
          cnt_d     = '0;
          timeout_d = 1'b0;
          srv0_rq_d = ~sel_d;
          srv1_rq_d = sel_d;
          state_d   = REQ;
        end
      end

      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An ack in the last allowed cycle wins over the timeout.
        if (sel_ack) begin
          if (!wr_ni_q) rdata_d = sel_datar;
          srv0_rq_d = 1'b0;
          srv1_rq_d = 1'b0;
          state_d   = RESP;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          srv0_rq_d = 1'b0;
          srv1_rq_d = 1'b0;
          state_d   = RESP;
        end
      end

      RESP: begin
        client_ack_d = 1'b1;
        err_d        = timeout_q;
        if (timeout_q)     client_datar_d = '1;
        else if (!wr_ni_q) client_datar_d = rdata_q;
        state_d = DROP;
      end

      DROP: begin
        if (!client_rq) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      sel_q          <= 1'b0;
      cnt_q          <= '0;
      addr_q         <= '0;
      wr_ni_q        <= 1'b0;
      dataw_q        <= '0;
      rdata_q        <= '0;
      timeout_q      <= 1'b0;
      srv0_rq_q      <= 1'b0;
      srv1_rq_q      <= 1'b0;
      client_ack_q   <= 1'b0;
      client_datar_q <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      wr_ni_q        <= wr_ni_d;
      dataw_q        <= dataw_d;
      rdata_q        <= rdata_d;
      timeout_q      <= timeout_d;
      srv0_rq_q      <= srv0_rq_d;
      srv1_rq_q      <= srv1_rq_d;
      client_ack_q   <= client_ack_d;
      client_datar_q <= client_datar_d;
      err_q          <= err_d;
    end
  end

  // Address, direction and write data fan out to both servers; only rq is routed.
  assign srv0_address = addr_q;
  assign srv0_wr_ni   = wr_ni_q;
  assign srv0_dataW   = dataw_q;
  assign srv0_rq      = srv0_rq_q;

  assign srv1_address = addr_q;
  assign srv1_wr_ni   = wr_ni_q;
  assign srv1_dataW   = dataw_q;
  assign srv1_rq      = srv1_rq_q;

  assign client_ack   = client_ack_q;
  assign client_dataR = client_datar_q;
  assign err          = err_q;

endmodule
